ifetch_queue: RTL and testbench

Instruction prefetch queue between the icache and the decode stage. It generates sequential fetch addresses and issues them to the icache/MMU. Returned 16-bit instruction parcels, each tagged with its PC and any fetch fault, are buffered in a small FIFO. Decode pops the FIFO with the existing iready/idone handshake, which decouples icache/qspi miss latency from decode and execute.

---
 rtl/ifetch_queue_pkg.sv | 21 ++
 rtl/ifq_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 98 +++++++++
 tb/tb_ifetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared layout of an instruction-queue entry: {ins, pc, fault}, with the fault flag in bit 0.
package ifetch_queue_pkg;

    localparam int   INS_W     = 16;
    localparam int   FAULT_BIT = 0;
    localparam int   PC_LSB    = 1;
    localparam logic HW_INC    = 1'b1;

    function automatic int pc_width(input int va);
        return va - 1;
    endfunction

    function automatic int entry_width(input int va);
        return INS_W + pc_width(va) + 1;
    endfunction

    function automatic int ins_lsb(input int va);
        return PC_LSB + pc_width(va);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic flop FIFO with a synchronous clear; only the pointers and the count are reset.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: clear wins, no write when full, no read when empty.
    always_comb begin
        push_ok_s = push & ~clear & (count_r != FULL_CNT);
        pop_ok_s  = pop  & ~clear & (count_r != '0);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential halfword fetches and buffers returned parcels for decode.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int             VA       = 16,
    parameter int             DEPTH    = 4,
    parameter logic [VA-2:0]  RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic [VA-2:0]  redirect_pc,
    output logic           ifetch,
    output logic [VA-2:0]  pc,
    input  logic           i_hit,
    input  logic [15:0]    ins_in,
    input  logic           i_fault,
    output logic           iready,
    output logic [15:0]    ins,
    output logic [VA-2:0]  ins_pc,
    output logic           ins_fault,
    input  logic           idone
);

    localparam int PC_W    = pc_width(VA);
    localparam int ENTRY_W = entry_width(VA);
    localparam int INS_LSB = ins_lsb(VA);

    logic [PC_W-1:0]         fpc_r;
    logic                    halt_r;
    logic                    ifetch_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic [$clog2(DEPTH):0]  count_s;
    logic [ENTRY_W-1:0]      wdata_s;
    logic [ENTRY_W-1:0]      rdata_s;

    // Fetch issue, push/pop qualification and the entry written on a push.
    always_comb begin
        ifetch_s = reset & ~flush & ~halt_r & ~full_s;
        push_s   = ifetch_s & (i_hit | i_fault);
        pop_s    = (count_s != '0) & idone;
        wdata_s  = {(i_fault ? 16'h0000 : ins_in), fpc_r, i_fault};
    end

    ifq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .clear (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Fetch PC and fault halt; flush redirects and releases the halt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_r  <= RESET_PC;
            halt_r <= 1'b0;
        end else if (flush) begin
            fpc_r  <= redirect_pc;
            halt_r <= 1'b0;
        end else if (push_s) begin
            if (i_fault) begin
                halt_r <= 1'b1;
            end else begin
                fpc_r  <= fpc_r + {{(PC_W-1){1'b0}}, HW_INC};
            end
        end
    end

    // Head entry presented to decode, zeroed while the queue is empty.
    always_comb begin
        if (empty_s) begin
            ins       = 16'h0000;
            ins_pc    = '0;
            ins_fault = 1'b0;
        end else begin
            ins       = rdata_s[INS_LSB +: INS_W];
            ins_pc    = rdata_s[PC_LSB +: PC_W];
            ins_fault = rdata_s[FAULT_BIT];
        end
    end

    assign ifetch = ifetch_s;
    assign pc     = fpc_r;
    assign iready = (count_s != '0);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and random stimulus for ifetch_queue checked against a queue-based reference model.
module tb_ifetch_queue;

    localparam int          VA    = 16;
    localparam int          DEPTH = 4;
    localparam logic [14:0] RPC   = 15'h100;

    typedef struct packed {
        logic [15:0] ins;
        logic [14:0] pc;
        logic        fault;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [14:0] redirect_pc;
    logic        ifetch;
    logic [14:0] pc;
    logic        i_hit;
    logic [15:0] ins_in;
    logic        i_fault;
    logic        iready;
    logic [15:0] ins;
    logic [14:0] ins_pc;
    logic        ins_fault;
    logic        idone;

    ent_t        q[$];
    logic [14:0] m_fpc;
    logic        m_halt;
    int          checks = 0;
    int          errors = 0;

    ifetch_queue #(.VA(VA), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
        .ifetch(ifetch), .pc(pc), .i_hit(i_hit), .ins_in(ins_in), .i_fault(i_fault),
        .iready(iready), .ins(ins), .ins_pc(ins_pc), .ins_fault(ins_fault), .idone(idone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ifetch();
        return reset && !flush && !m_halt && (q.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        ent_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("ifetch", {31'd0, ifetch}, {31'd0, model_ifetch()});
        chk("pc", {17'd0, pc}, {17'd0, m_fpc});
        chk("iready", {31'd0, iready}, {31'd0, q.size() != 0});
        chk("ins", {16'd0, ins}, {16'd0, h.ins});
        chk("ins_pc", {17'd0, ins_pc}, {17'd0, h.pc});
        chk("ins_fault", {31'd0, ins_fault}, {31'd0, h.fault});
    endtask

    task automatic drive(input logic f, input logic [14:0] rpc, input logic h,
                         input logic [15:0] d, input logic flt, input logic dn);
        flush = f; redirect_pc = rpc; i_hit = h; ins_in = d; i_fault = flt; idone = dn;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic f, input logic [14:0] rpc, input logic h,
                        input logic [15:0] d, input logic flt, input logic dn);
        logic do_fetch;
        ent_t e;
        drive(f, rpc, h, d, flt, dn);
        @(negedge clk);
        check_outputs();
        do_fetch = model_ifetch();
        @(posedge clk);
        if (f) begin
            q.delete();
            m_fpc  = rpc;
            m_halt = 1'b0;
        end else begin
            e.ins   = flt ? 16'h0000 : d;
            e.pc    = m_fpc;
            e.fault = flt;
            if (q.size() != 0 && dn) void'(q.pop_front());
            if (do_fetch && (h || flt)) begin
                q.push_back(e);
                if (flt) m_halt = 1'b1;
                else     m_fpc  = m_fpc + 15'd1;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        m_fpc = RPC; m_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_iready", {31'd0, iready}, 32'd0);
        chk("rst_ifetch", {31'd0, ifetch}, 32'd0);
        reset = 1'b1;

        // Fill: four hits, no decode
        for (int i = 0; i < 6; i++) step(1'b0, 15'h0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        #1;
        chk("full_ifetch", {31'd0, ifetch}, 32'd0);
        chk("full_head_pc", {17'd0, ins_pc}, 32'h100);

        // Single idone pulse while full
        step(1'b0, 15'h0, 1'b1, 16'h1111, 1'b0, 1'b1);
        drive(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("pulse_head", {17'd0, ins_pc}, 32'h101);
        chk("pulse_ifetch", {31'd0, ifetch}, 32'd1);
        chk("pulse_pc", {17'd0, pc}, 32'h104);
        step(1'b0, 15'h0, 1'b1, 16'h2222, 1'b0, 1'b0);

        // Drain to two entries, then flush with a same-cycle hit and pop
        step(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b1, 15'h2A0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        drive(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("flush_iready", {31'd0, iready}, 32'd0);
        chk("flush_pc", {17'd0, pc}, 32'h2A0);
        chk("flush_ifetch", {31'd0, ifetch}, 32'd1);

        // Streaming: continuous hit with continuous decode
        for (int i = 0; i < 10; i++) step(1'b0, 15'h0, 1'b1, 16'($urandom), 1'b0, 1'b1);

        // Fetch fault halts fetching until a flush
        step(1'b1, 15'h105, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 15'h0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
        drive(1'b0, 15'h0, 1'b1, 16'h0, 1'b0, 1'b0);
        #1;
        chk("fault_flag", {31'd0, ins_fault}, 32'd1);
        chk("fault_ins", {16'd0, ins}, 32'h0);
        chk("fault_pc", {17'd0, ins_pc}, 32'h105);
        chk("fault_halt", {31'd0, ifetch}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 15'h0, 1'b1, 16'h5555, 1'b0, 1'b1);
        step(1'b1, 15'h40, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 15'h0, 1'b1, 16'h4040, 1'b0, 1'b0);

        // PC wraps at the top of the halfword space
        step(1'b1, 15'h7FFF, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 15'h0, 1'b1, 16'h7777, 1'b0, 1'b1);
        drive(1'b0, 15'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("wrap_pc", {17'd0, pc}, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0), 15'($urandom),
                 ($urandom_range(0, 3) != 0), 16'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of a cycle
        step(1'b1, 15'h300, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 15'h0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        q.delete(); m_fpc = RPC; m_halt = 1'b0;
        chk("async_iready", {31'd0, iready}, 32'd0);
        chk("async_ifetch", {31'd0, ifetch}, 32'd0);
        chk("async_pc", {17'd0, pc}, {17'd0, RPC});
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), 15'($urandom),
                 ($urandom_range(0, 3) != 0), 16'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
